mem_arbiter: RTL and testbench

- Sits directly downstream of the CPU core: merges the core's instruction-fetch bus and data bus onto a single external memory/IO bus.
- Round-robin arbitration between the two requesters, with a bus-lock mode for locked data sequences.
- Registered grant state machine; one access is outstanding at a time and is held until the memory acknowledges it.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instruction/data bus arbiter with bus-lock support
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] instr_m_addr,
    output logic [15:0] instr_m_data_in,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    input  logic [19:1] data_m_addr,
    output logic [15:0] data_m_data_in,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    input  logic        d_io,
    input  logic        lock,
    output logic [19:1] q_m_addr,
    input  logic [15:0] q_m_data_in,
    output logic [15:0] q_m_data_out,
    output logic        q_m_access,
    input  logic        q_m_ack,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    output logic        q_m_io
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] LOCKED  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_d;
    logic       last_d_next;

    always_comb begin
        state_next  = state;
        last_d_next = last_d;
        case (state)
            IDLE: begin
                // A locked data sequence always wins; otherwise alternate on contention.
                if (data_m_access && lock)
                    state_next = GRANT_D;
                else if (data_m_access && instr_m_access)
                    state_next = last_d ? GRANT_I : GRANT_D;
                else if (instr_m_access)
                    state_next = GRANT_I;
                else if (data_m_access)
                    state_next = GRANT_D;
            end
            GRANT_I: begin
                if (q_m_ack) begin
                    state_next  = IDLE;
                    last_d_next = 1'b0;
                end
            end
            GRANT_D: begin
                if (q_m_ack) begin
                    state_next  = lock ? LOCKED : IDLE;
                    last_d_next = 1'b1;
                end
            end
            LOCKED: begin
                if (q_m_ack)
                    last_d_next = 1'b1;
                if (!lock && (!data_m_access || q_m_ack))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    always_comb begin
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_access   = 1'b0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = 2'b00;
        q_m_io       = 1'b0;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (state)
            GRANT_I: begin
                q_m_addr    = instr_m_addr;
                q_m_access  = 1'b1;
                q_m_bytesel = 2'b11;
                instr_m_ack = q_m_ack;
            end
            GRANT_D, LOCKED: begin
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                // Inside a lock the bus follows the core so consecutive accesses need no bubble.
                q_m_access   = (state == LOCKED) ? data_m_access : 1'b1;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                q_m_io       = d_io;
                data_m_ack   = q_m_ack;
            end
            default: ;
        endcase
    end

    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:1] instr_m_addr;
    logic [15:0] instr_m_data_in;
    logic        instr_m_access;
    logic        instr_m_ack;
    logic [19:1] data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_ack;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic        d_io;
    logic        lock;
    logic [19:1] q_m_addr;
    logic [15:0] q_m_data_in;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_ack;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;
    logic        q_m_io;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .instr_m_addr(instr_m_addr), .instr_m_data_in(instr_m_data_in),
        .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
        .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
        .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
        .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
        .data_m_bytesel(data_m_bytesel), .d_io(d_io), .lock(lock),
        .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
        .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
        .q_m_bytesel(q_m_bytesel), .q_m_io(q_m_io)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven and checked #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_m_addr = '0; instr_m_access = 1'b0;
        data_m_addr = '0; data_m_data_out = '0; data_m_access = 1'b0;
        data_m_wr_en = 1'b0; data_m_bytesel = 2'b00; d_io = 1'b0; lock = 1'b0;
        q_m_data_in = '0; q_m_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #2;
        tests_run++;
        if ({q_m_access, q_m_wr_en, q_m_bytesel, q_m_io, q_m_addr, q_m_data_out, instr_m_ack, data_m_ack} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: q_m_access=%b wr=%b bs=%b io=%b addr=%h dout=%h iack=%b dack=%b expected all 0",
                     q_m_access, q_m_wr_en, q_m_bytesel, q_m_io, q_m_addr, q_m_data_out, instr_m_ack, data_m_ack);
        end
        step();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            tests_run++;
            if (q_m_access !== 1'b0 || instr_m_ack !== 1'b0 || data_m_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle_c%0d: access=%b iack=%b dack=%b expected 0 0 0", c, q_m_access, instr_m_ack, data_m_ack);
            end
        end
    endtask

    task automatic test_instr_fetch();
        do_reset();
        step();
        instr_m_access = 1'b1; instr_m_addr = 19'h0FFFF;
        #1;
        tests_run++;
        if (q_m_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_c0_access: got %b expected 0", q_m_access);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) begin q_m_ack = 1'b1; q_m_data_in = 16'hBEEF; end
            #1;
            tests_run++;
            if (q_m_access !== 1'b1 || q_m_addr !== 19'h0FFFF || q_m_bytesel !== 2'b11 || q_m_wr_en !== 1'b0 || q_m_io !== 1'b0 || q_m_data_out !== 16'h0) begin
                tests_failed++;
                $display("FAIL fetch_c%0d_bus: access=%b addr=%h bs=%b wr=%b io=%b dout=%h expected 1 0ffff 11 0 0 0000",
                         c, q_m_access, q_m_addr, q_m_bytesel, q_m_wr_en, q_m_io, q_m_data_out);
            end
            tests_run++;
            if (instr_m_ack !== (c == 3) || data_m_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL fetch_c%0d_ack: iack=%b dack=%b expected %b 0", c, instr_m_ack, data_m_ack, (c == 3));
            end
        end
        tests_run++;
        if (instr_m_data_in !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL fetch_rdata: got %h expected beef", instr_m_data_in);
        end
        step();
        instr_m_access = 1'b0; q_m_ack = 1'b0;
        #1;
        tests_run++;
        if (q_m_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_after_ack_access: got %b expected 0", q_m_access);
        end
    endtask

    task automatic test_round_robin();
        logic exp_d;
        do_reset();
        step();
        instr_m_access = 1'b1; instr_m_addr = 19'h00111;
        data_m_access = 1'b1; data_m_addr = 19'h00222; data_m_wr_en = 1'b1; data_m_bytesel = 2'b10;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            step();
            q_m_ack = 1'b1;
            #1;
            tests_run++;
            if (data_m_ack !== exp_d || instr_m_ack !== !exp_d) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: dack=%b iack=%b expected %b %b", g, data_m_ack, instr_m_ack, exp_d, !exp_d);
            end
            tests_run++;
            if (q_m_addr !== (exp_d ? 19'h00222 : 19'h00111) || q_m_wr_en !== exp_d) begin
                tests_failed++;
                $display("FAIL rr_bus%0d: addr=%h wr=%b expected %h %b", g, q_m_addr, q_m_wr_en, (exp_d ? 19'h00222 : 19'h00111), exp_d);
            end
            step();
            q_m_ack = 1'b0;
            #1;
            tests_run++;
            if (q_m_access !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_bubble%0d: access=%b expected 0", g, q_m_access);
            end
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        step();
        // Make last_d=1 so without the lock the instruction side would win.
        data_m_access = 1'b1;
        step(); q_m_ack = 1'b1;
        step(); q_m_ack = 1'b0; data_m_access = 1'b0;
        step();
        lock = 1'b1; instr_m_access = 1'b1; instr_m_addr = 19'h00ABC;
        data_m_access = 1'b1; data_m_addr = 19'h01000; data_m_data_out = 16'h1234;
        data_m_wr_en = 1'b1; data_m_bytesel = 2'b01; d_io = 1'b1;
        for (int w = 0; w < 3; w++) begin
            step();
            q_m_ack = 1'b1;
            if (w == 2) lock = 1'b0;
            #1;
            tests_run++;
            if (q_m_access !== 1'b1 || data_m_ack !== 1'b1 || instr_m_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL lock_write%0d_ack: access=%b dack=%b iack=%b expected 1 1 0", w, q_m_access, data_m_ack, instr_m_ack);
            end
            tests_run++;
            if (q_m_io !== 1'b1 || q_m_data_out !== 16'h1234 || q_m_bytesel !== 2'b01 || q_m_wr_en !== 1'b1 || q_m_addr !== 19'h01000) begin
                tests_failed++;
                $display("FAIL lock_write%0d_bus: io=%b dout=%h bs=%b wr=%b addr=%h expected 1 1234 01 1 01000",
                         w, q_m_io, q_m_data_out, q_m_bytesel, q_m_wr_en, q_m_addr);
            end
        end
        step();
        q_m_ack = 1'b0; data_m_access = 1'b0; d_io = 1'b0;
        #1;
        tests_run++;
        if (q_m_access !== 1'b0 || instr_m_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_exit_idle: access=%b iack=%b expected 0 0", q_m_access, instr_m_ack);
        end
        step();
        q_m_ack = 1'b1;
        #1;
        tests_run++;
        if (instr_m_ack !== 1'b1 || q_m_addr !== 19'h00ABC || q_m_io !== 1'b0 || q_m_bytesel !== 2'b11) begin
            tests_failed++;
            $display("FAIL lock_instr_after: iack=%b addr=%h io=%b bs=%b expected 1 00abc 0 11", instr_m_ack, q_m_addr, q_m_io, q_m_bytesel);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step();
        data_m_access = 1'b1; data_m_addr = 19'h00055;
        step();
        #1;
        tests_run++;
        if (q_m_access !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pre_access: got %b expected 1", q_m_access);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (q_m_access !== 1'b0 || data_m_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: access=%b dack=%b expected 0 0", q_m_access, data_m_ack);
        end
        data_m_access = 1'b0;
        step();
        reset = 1'b1;
        step();
        #1;
        tests_run++;
        if (q_m_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: access=%b expected 0", q_m_access);
        end
        instr_m_access = 1'b1; instr_m_addr = 19'h00077;
        step();
        q_m_ack = 1'b1;
        #1;
        tests_run++;
        if (instr_m_ack !== 1'b1 || q_m_addr !== 19'h00077) begin
            tests_failed++;
            $display("FAIL midreset_regrant: iack=%b addr=%h expected 1 00077", instr_m_ack, q_m_addr);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_drop_before_ack();
        do_reset();
        step();
        data_m_access = 1'b1; data_m_addr = 19'h00333;
        step();
        data_m_access = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            tests_run++;
            if (q_m_access !== 1'b1 || q_m_addr !== 19'h00333) begin
                tests_failed++;
                $display("FAIL drop_hold%0d: access=%b addr=%h expected 1 00333", c, q_m_access, q_m_addr);
            end
        end
        step();
        q_m_ack = 1'b1;
        #1;
        tests_run++;
        if (data_m_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_ack: dack=%b expected 1", data_m_ack);
        end
        step();
        q_m_ack = 1'b0;
        #1;
        tests_run++;
        if (q_m_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_idle: access=%b expected 0", q_m_access);
        end
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_round_robin();
        test_lock();
        test_reset_mid_grant();
        test_drop_before_ack();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
